// File: rtl/instr_issuer.sv
// Instruction-issue front end: fetches from a 1-cycle synchronous instruction memory,
// screens the opcode, and drives the s/w start-done handshake toward the controller.
module instr_issuer #(
    parameter int ADDR_W      = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       instr,
    output logic [2:0]        opcode,
    output logic [1:0]        op,
    output logic              s,
    input  logic              w,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [15:0]       retired
);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        CAPTURE,
        DECODE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        HALT,
        ERR
    } state_t;

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    // ack_cnt counts WAIT_ACK cycles already spent; leaving on the last allowed one
    // puts ERR exactly ACK_TIMEOUT cycles after the ISSUE cycle.
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 2);

    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] ack_cnt;
    logic             is_halt;
    logic             is_valid;
    logic             ack_expired;

    assign opcode    = instr[15:13];
    assign op        = instr[12:11];
    assign imem_addr = pc;

    // Screening works on the registered instruction, so it is stable in DECODE.
    always_comb begin
        is_halt  = (opcode == OPC_HALT);
        is_valid = 1'b0;
        unique case (opcode)
            OPC_ALU:  is_valid = 1'b1;
            OPC_MOV:  is_valid = (op == 2'b00) || (op == 2'b10);
            OPC_HALT: is_valid = 1'b1;
            default:  is_valid = 1'b0;
        endcase
    end

    assign ack_expired = (ack_cnt >= ACK_LAST);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, HALT, ERR: begin
                if (run) state_next = FETCH;
            end
            FETCH:   state_next = CAPTURE;
            CAPTURE: state_next = DECODE;
            DECODE: begin
                if (is_halt)       state_next = HALT;
                else if (!is_valid) state_next = ERR;
                else if (w)        state_next = ISSUE;
            end
            ISSUE:   state_next = WAIT_ACK;
            WAIT_ACK: begin
                if (!w)              state_next = WAIT_DONE;
                else if (ack_expired) state_next = ERR;
            end
            WAIT_DONE: begin
                if (w) state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= '0;
            instr   <= '0;
            retired <= '0;
            ack_cnt <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE, HALT, ERR: begin
                    if (run) begin
                        pc      <= '0;
                        retired <= '0;
                    end
                end
                CAPTURE: instr <= imem_rdata;
                ISSUE:   ack_cnt <= '0;
                WAIT_ACK: begin
                    if (w) ack_cnt <= ack_cnt + CNT_W'(1);
                end
                WAIT_DONE: begin
                    if (w) begin
                        pc <= pc + ADDR_W'(1);
                        if (retired != '1) retired <= retired + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s      = (state == ISSUE);
    assign err    = (state == ERR);
    assign halted = (state == HALT) || (state == ERR);
    assign busy   = !((state == IDLE) || (state == HALT) || (state == ERR));

endmodule

// File: tb/tb_instr_issuer.sv
// Scoreboarded bench for instr_issuer: a memory model and a controller model answer the
// handshake; each expected issue is queued when stimulus is set up and popped on every s pulse.
module tb_instr_issuer;

    localparam int ADDR_W      = 2;
    localparam int ACK_TIMEOUT = 15;
    localparam int BUSY_CYC    = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_rdata;
    logic [15:0]       instr;
    logic [2:0]        opcode;
    logic [1:0]        op;
    logic              s;
    logic              w;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;
    logic              err;
    logic [15:0]       retired;

    instr_issuer #(
        .ADDR_W      (ADDR_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .opcode     (opcode),
        .op         (op),
        .s          (s),
        .w          (w),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .err        (err),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Controller model: w drops on the edge that ends ISSUE, rises after BUSY_CYC cycles.
    logic        manual = 1'b1;
    logic        w_hold = 1'b1;
    logic        w_auto = 1'b1;
    int          busy_left = 0;
    logic        prev_s = 1'b0;
    int          s_count = 0;
    logic [31:0] exp_q[$];

    assign w = manual ? w_hold : w_auto;

    always @(negedge clk) begin
        if (reset) begin
            w_auto    <= 1'b1;
            busy_left <= 0;
            prev_s    <= 1'b0;
        end else begin
            prev_s <= s;
            if (s) begin
                check("s_with_w_low", w, 1);
                check("s_two_cycles", prev_s, 0);
                check("s_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("issue_instr", instr, exp_q[0][15:0]);
                    check("issue_opcode", opcode, exp_q[0][15:13]);
                    check("issue_op", op, exp_q[0][12:11]);
                    check("issue_pc", pc, exp_q[0][31:16]);
                    void'(exp_q.pop_front());
                end
                s_count   <= s_count + 1;
                w_auto    <= 1'b0;
                busy_left <= BUSY_CYC;
            end else if (busy_left > 0) begin
                busy_left <= busy_left - 1;
                if (busy_left == 1) w_auto <= 1'b1;
            end
        end
    end

    task automatic pulse_run(output int c0);
        c0  = cyc;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_halted(input string tag, input int max);
        for (int i = 0; i < max && !halted; i++) @(negedge clk);
        check(tag, halted, 1);
    endtask

    task automatic wait_s(input string tag, input int max);
        for (int i = 0; i < max && s !== 1'b1; i++) @(negedge clk);
        check(tag, s, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int base;
        int t;

        reset = 1'b1;
        run   = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_s", s, 0);
        check("rst_pc", pc, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_instr", instr, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        check("rst_retired", retired, 0);
        reset = 1'b0;
        @(negedge clk);

        // Program execution: MOV, ADD, HALT
        manual = 1'b0;
        mem[0] = 16'hD105; mem[1] = 16'hA0A1; mem[2] = 16'hE000; mem[3] = 16'h0000;
        exp_q.push_back({16'd0, 16'hD105});
        exp_q.push_back({16'd1, 16'hA0A1});
        base = s_count;
        pulse_run(c0);
        check("t1_busy_fetch", busy, 1);
        wait_s("t1_first_s", 10);
        check("t1_s_latency", cyc, c0 + 4);
        wait_halted("t1_halt", 80);
        check("t1_s_count", s_count - base, 2);
        check("t1_pc", pc, 2);
        check("t1_retired", retired, 2);
        check("t1_err", err, 0);

        // Invalid opcode, then recovery by a new run
        mem[0] = 16'h2000;
        base = s_count;
        pulse_run(c0);
        repeat (2) @(negedge clk);
        check("t2_err_early", err, 0);
        @(negedge clk);
        check("t2_err", err, 1);
        check("t2_halted", halted, 1);
        check("t2_busy", busy, 0);
        check("t2_pc", pc, 0);
        check("t2_no_s", s_count - base, 0);
        mem[0] = 16'hD105;
        exp_q.push_back({16'd0, 16'hD105});
        exp_q.push_back({16'd1, 16'hA0A1});
        pulse_run(c0);
        check("t2_err_cleared", err, 0);
        check("t2_refetch_addr", imem_addr, 0);
        wait_halted("t2_halt", 80);
        check("t2_pc_final", pc, 2);
        check("t2_retired", retired, 2);

        // Controller busy while in DECODE
        manual = 1'b1;
        w_hold = 1'b0;
        exp_q.push_back({16'd0, 16'hD105});
        exp_q.push_back({16'd1, 16'hA0A1});
        pulse_run(c0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check("t3_s_held", s, 0);
            if (i < 5) @(negedge clk);
        end
        w_hold = 1'b1;
        manual = 1'b0;
        @(negedge clk);
        check("t3_s_after_w", s, 1);
        check("t3_s_cycle", cyc, c0 + 9);
        wait_halted("t3_halt", 80);
        check("t3_pc", pc, 2);

        // Acknowledge timeout
        manual = 1'b1;
        w_hold = 1'b1;
        mem[0] = 16'hA0A1;
        exp_q.push_back({16'd0, 16'hA0A1});
        pulse_run(c0);
        wait_s("t4_s", 10);
        t = cyc;
        for (int i = 0; i < 40 && !err; i++) @(negedge clk);
        check("t4_err", err, 1);
        check("t4_err_cycle", cyc, t + ACK_TIMEOUT);
        check("t4_retired", retired, 0);
        check("t4_pc", pc, 0);
        manual = 1'b0;

        // PC wrap with four MOVs and no HALT
        mem[0] = 16'hC005; mem[1] = 16'hD105; mem[2] = 16'hC205; mem[3] = 16'hD305;
        exp_q.push_back({16'd0, 16'hC005});
        exp_q.push_back({16'd1, 16'hD105});
        exp_q.push_back({16'd2, 16'hC205});
        exp_q.push_back({16'd3, 16'hD305});
        exp_q.push_back({16'd0, 16'hC005});
        base = s_count;
        pulse_run(c0);
        for (int i = 0; i < 200 && s_count < base + 5; i++) @(negedge clk);
        check("t5_s_count", s_count - base, 5);
        check("t5_pc_wrapped", pc, 0);
        check("t5_retired", retired, 4);
        check("t5_busy", busy, 1);

        // Reset asserted while in WAIT_DONE
        @(negedge clk);
        check("t6_wait_done_w", w, 0);
        check("t6_wait_done_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_s", s, 0);
        check("t6_busy", busy, 0);
        check("t6_pc", pc, 0);
        check("t6_retired", retired, 0);
        check("t6_halted", halted, 0);
        check("t6_err", err, 0);
        check("t6_instr", instr, 0);
        reset = 1'b0;
        mem[1] = 16'hE000;
        @(negedge clk);
        exp_q.push_back({16'd0, 16'hC005});
        pulse_run(c0);
        wait_s("t6_restart_s", 10);
        check("t6_restart_latency", cyc, c0 + 4);
        wait_halted("t6_halt", 80);
        check("t6_pc_final", pc, 1);
        check("t6_retired_final", retired, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
